fma_share_pipe: RTL

// - Pipelined shared-product multiply-add. One product a*b is computed per transaction
//   and added to N_ADD independent addends: res[i] = a*b + c[i].
// - Generalises the single-cycle two-addend shared FMA to:
//   - a parametric addend count;
//   - selectable signed or unsigned operands;
//   - valid/ready flow control through a 2-stage stallable pipeline.
// - Sits between operand staging and result writeback in sum-of-products datapaths.
//

---
 rtl/fma_share_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/fma_share_pipe.sv
// Shared-product multiply-add: res[i] = a*b + c[i] for N_ADD addends, signed or unsigned per transaction.
// Latency: 2 cycles from input transfer to out_valid (S1 = product/extend, S2 = add); 1 transaction/cycle.
// Backpressure: out_ready stalls S2, a full stalled S2 stalls S1; in_ready = S1 can advance (no bubbles).
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid/in_ready    operand handshake; in_signed, a, b, c_flat travel together
//   out_valid/out_ready  result handshake; res_flat holds res[i] at [i*2*BW +: 2*BW]
//   out_count            16-bit output-transfer counter, present only when FMA_SHARE_STAT_EN is defined
//
// Optional feature macro: FMA_SHARE_STAT_EN (adds out_count and its counter; datapath unchanged).

module fma_share_pipe #(
    parameter int BW    = 8,
    parameter int N_ADD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_signed,
    input  logic [BW-1:0]            a,
    input  logic [BW-1:0]            b,
    input  logic [N_ADD*BW-1:0]      c_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_ADD*2*BW-1:0]    res_flat
`ifdef FMA_SHARE_STAT_EN
    ,
    output logic [15:0]              out_count
`endif
);

    localparam int RW = 2 * BW;

    // Stage 1 state
    logic                        s1_valid;
    logic [RW-1:0]               s1_p;
    logic [N_ADD-1:0][RW-1:0]    s1_c;

    // Stage control
    logic s2_adv;
    logic s1_adv;

    // Stage 1 combinational inputs
    logic [RW-1:0]               a_ext;
    logic [RW-1:0]               b_ext;
    logic [RW-1:0]               prod;
    logic [N_ADD-1:0][RW-1:0]    c_ext;

    // Stage 2 combinational sums
    logic [N_ADD*RW-1:0]         res_nxt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Extending both operands to 2*BW and keeping only the low 2*BW bits of the
    // product gives the correct result in both modes: modular multiplication of
    // sign-extended values equals the two's complement product, and the true
    // product always fits in 2*BW bits.
    always_comb begin
        a_ext = in_signed ? {{BW{a[BW-1]}}, a} : {{BW{1'b0}}, a};
        b_ext = in_signed ? {{BW{b[BW-1]}}, b} : {{BW{1'b0}}, b};
        prod  = a_ext * b_ext;
        for (int i = 0; i < N_ADD; i++) begin
            c_ext[i] = in_signed ? {{BW{c_flat[i*BW + BW - 1]}}, c_flat[i*BW +: BW]}
                                 : {{BW{1'b0}}, c_flat[i*BW +: BW]};
        end
    end

    always_comb begin
        res_nxt = '0;
        for (int i = 0; i < N_ADD; i++) begin
            res_nxt[i*RW +: RW] = s1_p + s1_c[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_c      <= '0;
            out_valid <= 1'b0;
            res_flat  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_p <= prod;
                    s1_c <= c_ext;
                end
            end
            // Only load on a real transaction so res_flat never shows stale-bubble data.
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    res_flat <= res_nxt;
                end
            end
        end
    end

`ifdef FMA_SHARE_STAT_EN
    // Reset has priority, so a transfer coinciding with reset is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + 16'd1;
        end
    end
`endif

endmodule
